// File: rtl/serial_comparator.sv
// serial_comparator -- MSB-first, CHUNK-bits-per-cycle signed/unsigned magnitude compare
// with start/busy/done handshake. Rev 1.0
`default_nettype none

module serial_comparator #(
  parameter int BITS       = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            unsign,
  output logic            busy,
  output logic            done,
  output logic            lessThan,
  output logic            equal,
  output logic            greaterThan
);

  localparam int NCHUNK = BITS / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [BITS-1:0] MSB_MASK = BITS'(1) << (BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [BITS-1:0] op_a, op_b;
  logic [IW-1:0]   idx;
  logic            diff_seen, diff_gt;
  logic [CHUNK-1:0] ca, cb;
  logic            chunk_ne, chunk_lt;
  logic            accept, finish, record, fin_lt, fin_gt;

  generate
    if (NCHUNK == 1) begin : g_single
      assign ca = op_a;
      assign cb = op_b;
    end else begin : g_multi
      assign ca = op_a[int'(idx) * CHUNK +: CHUNK];
      assign cb = op_b[int'(idx) * CHUNK +: CHUNK];
    end
  endgenerate

  assign chunk_ne = (ca != cb);
  assign chunk_lt = (ca < cb);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    record   = 1'b0;
    fin_lt   = 1'b0;
    fin_gt   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (EARLY_EXIT && chunk_ne) begin
          finish = 1'b1;
          fin_lt = chunk_lt;
          fin_gt = !chunk_lt;
        end else if (idx == '0) begin
          finish = 1'b1;
          // The earliest (most significant) difference outranks the last chunk.
          if (diff_seen) begin
            fin_lt = !diff_gt;
            fin_gt = diff_gt;
          end else if (chunk_ne) begin
            fin_lt = chunk_lt;
            fin_gt = !chunk_lt;
          end
        end else if (chunk_ne && !diff_seen) begin
          record = 1'b1;
        end
        if (finish) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_a        <= '0;
      op_b        <= '0;
      idx         <= '0;
      diff_seen   <= 1'b0;
      diff_gt     <= 1'b0;
      lessThan    <= 1'b0;
      equal       <= 1'b0;
      greaterThan <= 1'b0;
    end else begin
      if (accept) begin
        // Flipping both sign bits maps two's-complement order onto unsigned order.
        op_a      <= unsign ? a : (a ^ MSB_MASK);
        op_b      <= unsign ? b : (b ^ MSB_MASK);
        idx       <= IW'(NCHUNK - 1);
        diff_seen <= 1'b0;
        diff_gt   <= 1'b0;
      end else if (state == RUN && !finish) begin
        idx <= idx - IW'(1);
        if (record) begin
          diff_seen <= 1'b1;
          diff_gt   <= !chunk_lt;
        end
      end
      if (finish) begin
        lessThan    <= fin_lt;
        greaterThan <= fin_gt;
        equal       <= !(fin_lt || fin_gt);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

`default_nettype wire
